seven_seg_scanner: RTL and testbench

Time-multiplexed scan controller for the calculator's 4-digit common-anode seven-segment display. It latches a 16-bit result as four hex/BCD nibbles and cycles through the digits at a divided refresh rate. For each digit it drives the active-low anode enables, the decimal point, and the 4-bit nibble that feeds the downstream nibble-to-segment decoder. Updates are double-buffered and only take effect at a frame boundary, so a digit never shows a mix of old and new values. Optional leading-zero blanking is provided.

---
 rtl/seven_seg_if.sv | 22 ++
 rtl/seven_seg_scanner.sv | 118 +++++++++++
 tb/tb_seven_seg_scanner.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_if.sv
// Signal bundle between the display scanner and its client: value/dp load path in,
// multiplexed digit, anode and decimal-point drive out.
interface seven_seg_if;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit_out;
    logic [3:0]  an_out;
    logic        dp_out;
    logic        frame_done;

    modport master (
        output value_in, dp_in, load, blank_lz,
        input  digit_out, an_out, dp_out, frame_done
    );

    modport slave (
        input  value_in, dp_in, load, blank_lz,
        output digit_out, an_out, dp_out, frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode scan controller: double-buffered value, frame-aligned swap,
// leading-zero blanking and a one-cycle anode dead time between digits.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    seven_seg_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_e;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             tick;
    digit_e           state_reg, state_next;
    logic [1:0]       idx;
    logic             swap;

    logic [15:0] pend_val_reg, act_val_reg;
    logic [3:0]  pend_dp_reg, act_dp_reg;
    logic        pend_valid_reg;
    logic        idx_moved_reg;

    logic [3:0]  digit_reg, digit_next;
    logic [3:0]  an_reg, an_next;
    logic        dp_reg, dp_next;
    logic        frame_done_reg;

    logic [3:0]  nib [4];
    logic [3:0]  blank_vec;

    assign idx  = state_reg;
    assign swap = tick && (state_reg == DIG3);

    always_comb begin
        tick     = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
        cnt_next = tick ? '0 : cnt_reg + 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        if (tick) begin
            case (state_reg)
                DIG0:    state_next = DIG1;
                DIG1:    state_next = DIG2;
                DIG2:    state_next = DIG3;
                default: state_next = DIG0;
            endcase
        end
    end

    // A digit k>0 is blanked when it and every more significant nibble are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign nib[gi] = act_val_reg[gi*4 +: 4];
            if (gi == 0) begin : g_lsd
                assign blank_vec[gi] = 1'b0;
            end else begin : g_msd
                assign blank_vec[gi] = bus.blank_lz && (act_val_reg[15:gi*4] == '0);
            end
        end
    endgenerate

    // dp follows the anode so it is never asserted while all anodes are off.
    always_comb begin
        digit_next = nib[idx];
        an_next    = ~(4'b0001 << idx);
        dp_next    = ~act_dp_reg[idx];
        if (idx_moved_reg || blank_vec[idx]) begin
            an_next = 4'b1111;
            dp_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            state_reg      <= DIG0;
            idx_moved_reg  <= 1'b0;
            pend_val_reg   <= '0;
            pend_dp_reg    <= '0;
            pend_valid_reg <= 1'b0;
            act_val_reg    <= '0;
            act_dp_reg     <= '0;
            digit_reg      <= '0;
            an_reg         <= 4'b1111;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            state_reg      <= state_next;
            idx_moved_reg  <= tick;
            digit_reg      <= digit_next;
            an_reg         <= an_next;
            dp_reg         <= dp_next;
            frame_done_reg <= swap;
            if (swap && pend_valid_reg) begin
                act_val_reg <= pend_val_reg;
                act_dp_reg  <= pend_dp_reg;
            end
            // A load on the swap edge refills pending after the old value moved out.
            if (bus.load) begin
                pend_val_reg   <= bus.value_in;
                pend_dp_reg    <= bus.dp_in;
                pend_valid_reg <= 1'b1;
            end else if (swap) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.digit_out  = digit_reg;
    assign bus.an_out     = an_reg;
    assign bus.dp_out     = dp_reg;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: timeline-based reference model checked every cycle,
// directed scenarios with literal frame expectations, then randomized loads and resets.
module tb_seven_seg_scanner;
    localparam int R = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_if bus();
    seven_seg_scanner #(.REFRESH_DIV(R)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: position in the scan timeline ----------------
    int          n;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_adp, m_pdp;
    logic        m_pv;
    logic [3:0]  e_dig, e_an;
    logic        e_dp, e_fd;

    function automatic logic blanked(input logic [15:0] v, input int k, input logic bl);
        if (!bl || k == 0) return 1'b0;
        return (v >> (4 * k)) == 16'h0;
    endfunction

    initial begin
        int  p, idx;
        logic dead, bl;
        n = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_pv = 1'b0;
                e_dig = 4'h0; e_an = 4'hF; e_dp = 1'b1; e_fd = 1'b0;
            end else begin
                p    = n;
                n    = n + 1;
                idx  = (p / R) % 4;
                dead = (p > 0) && (p % R == 0);
                bl   = blanked(m_act, idx, bus.blank_lz);
                e_dig = m_act[4*idx +: 4];
                e_an  = (dead || bl) ? 4'hF : ~(4'b0001 << idx);
                e_dp  = (dead || bl) ? 1'b1 : ~m_adp[idx];
                e_fd  = (n % (4 * R)) == 0;
                if (e_fd && m_pv) begin
                    m_act = m_pend; m_adp = m_pdp; m_pv = 1'b0;
                end
                if (bus.load) begin
                    m_pend = bus.value_in; m_pdp = bus.dp_in; m_pv = 1'b1;
                end
            end
            #1;
            checks++;
            if ({bus.digit_out, bus.an_out, bus.dp_out, bus.frame_done} !== {e_dig, e_an, e_dp, e_fd}) begin
                errors++;
                $display("FAIL model t=%0t digit %h/%h an %b/%b dp %b/%b fd %b/%b", $time,
                         bus.digit_out, e_dig, bus.an_out, e_an, bus.dp_out, e_dp, bus.frame_done, e_fd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        bus.value_in = v; bus.dp_in = dp; bus.load = 1'b1;
        $display("load value=%h dp=%b blank_lz=%b t=%0t", v, dp, bus.blank_lz, $time);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic wait_fd();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * R + 2 && !seen; i++) begin
            @(negedge clk);
            if (bus.frame_done) seen = 1'b1;
        end
        chk("frame_done_timeout", {15'h0, seen}, 16'h1);
    endtask

    // Called on the cycle where frame_done is high; checks the whole next frame.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] lit, input logic [3:0] dpm);
        int k, slot;
        for (int j = 1; j <= 4 * R; j++) begin
            @(negedge clk);
            k    = (j - 1) / R;
            slot = (j - 1) % R;
            chk("frame_digit", {12'h0, bus.digit_out}, {12'h0, v[4*k +: 4]});
            if (slot == 0 || !lit[k]) begin
                chk("frame_an", {12'h0, bus.an_out}, 16'h000F);
                chk("frame_dp", {15'h0, bus.dp_out}, 16'h1);
            end else begin
                chk("frame_an", {12'h0, bus.an_out}, {12'h0, ~(4'b0001 << k)});
                chk("frame_dp", {15'h0, bus.dp_out}, {15'h0, ~dpm[k]});
            end
            chk("frame_fd", {15'h0, bus.frame_done}, {15'h0, (j == 4 * R)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed then random stimulus ----------------
    initial begin
        logic [15:0] v;
        bus.value_in = '0; bus.dp_in = '0; bus.load = 1'b0; bus.blank_lz = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", {12'h0, bus.an_out}, 16'h000F);
        chk("reset_dp", {15'h0, bus.dp_out}, 16'h1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an", {12'h0, bus.an_out}, 16'h000E);
        chk("first_digit", {12'h0, bus.digit_out}, 16'h0);

        // scan order
        load_val(16'h12AB, 4'b0000);
        wait_fd();
        check_frame(16'h12AB, 4'b1111, 4'b0000);

        // leading zeros
        bus.blank_lz = 1'b1;
        load_val(16'h0005, 4'b0000); wait_fd(); check_frame(16'h0005, 4'b0001, 4'b0000);
        load_val(16'h0000, 4'b0000); wait_fd(); check_frame(16'h0000, 4'b0001, 4'b0000);
        load_val(16'h0100, 4'b0000); wait_fd(); check_frame(16'h0100, 4'b0111, 4'b0000);

        // buffering: load while idx==1, then two loads in one frame
        bus.blank_lz = 1'b0;
        repeat (6) @(negedge clk);
        load_val(16'h1111, 4'b0000); wait_fd(); check_frame(16'h1111, 4'b1111, 4'b0000);
        load_val(16'h2222, 4'b0000);
        repeat (3) @(negedge clk);
        load_val(16'h3333, 4'b0000); wait_fd(); check_frame(16'h3333, 4'b1111, 4'b0000);

        // load coincident with the swap edge
        load_val(16'h5555, 4'b0000);
        repeat (4 * R - 2) @(negedge clk);
        bus.value_in = 16'h4444; bus.dp_in = 4'b0000; bus.load = 1'b1;
        $display("load value=4444 dp=0000 coincident with swap t=%0t", $time);
        @(negedge clk);
        bus.load = 1'b0;
        chk("coincident_fd", {15'h0, bus.frame_done}, 16'h1);
        check_frame(16'h5555, 4'b1111, 4'b0000);
        check_frame(16'h4444, 4'b1111, 4'b0000);

        // decimal point, then dp suppressed on a blanked digit
        load_val(16'h1234, 4'b0100); wait_fd(); check_frame(16'h1234, 4'b1111, 4'b0100);
        bus.blank_lz = 1'b1;
        load_val(16'h0001, 4'b0100); wait_fd(); check_frame(16'h0001, 4'b0001, 4'b0000);

        // mid-operation reset discards pending load
        load_val(16'h9999, 4'b1111);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_an", {12'h0, bus.an_out}, 16'h000F);
        chk("midreset_dp", {15'h0, bus.dp_out}, 16'h1);
        chk("midreset_digit", {12'h0, bus.digit_out}, 16'h0);
        chk("midreset_fd", {15'h0, bus.frame_done}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerelease_an", {12'h0, bus.an_out}, 16'h000E);
        wait_fd();
        check_frame(16'h0000, 4'b0001, 4'b0000);

        // randomized loads, blanking toggles and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                $display("reset pulse t=%0t", $time);
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 7) == 0) begin
                v = 16'($urandom);
                v = v >> (4 * $urandom_range(0, 4));
                load_val(v, 4'($urandom));
            end else begin
                @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
